// File: rtl/unary_add_multi.sv
`default_nettype none
// ============================================================================
// Module   : unary_add_multi
// Brief    : CH-channel unary accumulator re-serialised as an OUT_LEN-cycle
//            thermometer stream with sticky overflow. Define
//            UNARY_ADD_SCALED_EN to emit floor(sum/CH) instead of the sum.
// Revision : 1.0 - initial release
// ============================================================================
module unary_add_multi #(
    parameter int CH      = 2,
    parameter int OUT_LEN = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          read_or_write,
    input  logic [CH-1:0] din,
    output logic          dout,
    output logic          C,
    output logic          busy,
    output logic          done
);

`ifdef UNARY_ADD_SCALED_EN
    localparam int c_raw_max = CH * OUT_LEN;
`else
    localparam int c_raw_max = OUT_LEN;
`endif
    localparam int c_acc_w = $clog2(c_raw_max + 1);
    localparam int c_idx_w = $clog2(OUT_LEN + 1);
    localparam int c_sum_w = $clog2(c_raw_max + CH + 1);
    localparam int c_pop_w = $clog2(CH + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_EMIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t               r_state;
    logic [c_acc_w-1:0]   r_acc;
    logic [c_idx_w-1:0]   r_idx;
    logic                 r_dout;
    logic                 r_c;
    logic                 r_busy;
    logic                 r_done;

    logic [c_pop_w-1:0]   w_pop;
    logic [c_sum_w-1:0]   w_sum;
    logic                 w_ovf;
    logic [c_acc_w-1:0]   w_acc_next;
    logic [c_acc_w-1:0]   w_sum_out;
    logic                 w_bit;

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < CH; i++) begin
            w_pop = w_pop + c_pop_w'(din[i]);
        end
    end

    // Widened sum so the overflow test sees the true raw value.
    assign w_sum      = c_sum_w'(r_acc) + c_sum_w'(w_pop);
    assign w_ovf      = (w_sum > c_sum_w'(c_raw_max));
    assign w_acc_next = w_ovf ? c_acc_w'(c_raw_max) : w_sum[c_acc_w-1:0];

`ifdef UNARY_ADD_SCALED_EN
    localparam logic [c_acc_w-1:0] c_ch_div = c_acc_w'(CH);
    assign w_sum_out = r_acc / c_ch_div;
`else
    assign w_sum_out = r_acc;
`endif

    // r_idx is 0 outside EMIT, so this also yields bit 0 on the start edge.
    assign w_bit = (c_acc_w'(r_idx) < w_sum_out);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_acc   <= '0;
            r_idx   <= '0;
            r_dout  <= 1'b0;
            r_c     <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    r_idx  <= '0;
                    if (en) begin
                        r_busy <= 1'b1;
                        if (read_or_write) begin
                            r_state <= S_EMIT;
                            r_acc   <= '0;
                            r_dout  <= 1'b0;
                            r_idx   <= c_idx_w'(1);
                        end else begin
                            r_state <= S_ACCUM;
                            r_acc   <= w_acc_next;
                            r_c     <= w_ovf;
                        end
                    end
                end
                S_ACCUM: begin
                    if (en) begin
                        if (read_or_write) begin
                            r_state <= S_EMIT;
                            r_dout  <= w_bit;
                            r_idx   <= c_idx_w'(1);
                        end else begin
                            r_acc <= w_acc_next;
                            if (w_ovf) begin
                                r_c <= 1'b1;
                            end
                        end
                    end
                end
                S_EMIT: begin
                    if (r_idx == c_idx_w'(OUT_LEN)) begin
                        r_state <= S_DONE;
                        r_dout  <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_acc   <= '0;
                        r_idx   <= '0;
                    end else begin
                        r_dout <= w_bit;
                        r_idx  <= r_idx + c_idx_w'(1);
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign dout = r_dout;
    assign C    = r_c;
    assign busy = r_busy;
    assign done = r_done;

endmodule
`default_nettype wire
